mac_seq_ctrl: RTL and testbench

//  Job sequencer for the FloatSD4 MAC pipeline (stg1..stg4). Accepts a job of LEN terms,

---
 rtl/mac_seq_ctrl_if.sv | 40 ++++
 rtl/mac_seq_ctrl.sv | 126 ++++++++++++
 tb/tb_mac_seq_ctrl.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_seq_ctrl_if.sv
// Handshake and job bus between the MAC job sequencer and its neighbours
// (operand fetch, result writer, MAC stage chain, job issuer).
interface mac_seq_ctrl_if #(
    parameter int LEN_W = 10,
    parameter int QF_W  = 5
);
    // job control
    logic             i_start;
    logic [LEN_W-1:0] i_len;
    logic [QF_W-1:0]  i_q_frac;
    logic             o_busy;
    logic             o_done;
    logic             o_err;
    // operand side / stage 1
    logic             i_src_valid;
    logic             o_src_ready;
    logic             o_mac_valid;
    logic             o_mac_inhibit;
    logic             o_first;
    logic             o_last;
    logic [QF_W-1:0]  o_q_frac;
    // stage 4 / result side
    logic             i_res_valid;
    logic             i_dst_ready;
    logic             o_res_last;

    // environment side: drives job requests, operands and results
    modport master (
        output i_start, i_len, i_q_frac, i_src_valid, i_res_valid, i_dst_ready,
        input  o_busy, o_done, o_err, o_src_ready, o_mac_valid, o_mac_inhibit,
               o_first, o_last, o_q_frac, o_res_last
    );

    // sequencer side
    modport slave (
        input  i_start, i_len, i_q_frac, i_src_valid, i_res_valid, i_dst_ready,
        output o_busy, o_done, o_err, o_src_ready, o_mac_valid, o_mac_inhibit,
               o_first, o_last, o_q_frac, o_res_last
    );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Job sequencer for the FloatSD4 MAC pipeline: issues one operand beat per
// cycle into stage 1, holds the whole chain on result back-pressure, counts
// retired results and pulses done once the last result leaves stage 4.
module mac_seq_ctrl #(
    parameter int PIPE_DEPTH = 4,
    parameter int LEN_W      = 10,
    parameter int QF_W       = 5
) (
    input  logic         i_clk,
    input  logic         i_rst,
    mac_seq_ctrl_if.slave bus
);
    localparam int IF_W = $clog2(PIPE_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_m1;
    logic [LEN_W-1:0] issued;
    logic [LEN_W-1:0] retired;
    logic [IF_W-1:0]  inflight;
    logic [QF_W-1:0]  q_frac_q;

    logic             busy;
    logic             inhibit;
    logic             src_ready;
    logic             issue;
    logic             retire;

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: a zero-length job goes straight to DONE
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.i_start) begin
                    state_nxt = (bus.i_len != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                if (issue && issued == len_m1) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (retire && retired == len_m1) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output and handshake decode
    always_comb begin
        len_m1    = len_q - LEN_W'(1);
        busy      = (state == RUN) || (state == DRAIN);
        inhibit   = bus.i_res_valid & ~bus.i_dst_ready;
        src_ready = (state == RUN) && !inhibit && (issued < len_q)
                    && (inflight < IF_W'(PIPE_DEPTH));
        issue     = bus.i_src_valid & src_ready;
        // results arriving outside a job, or with nothing in flight, are stale
        retire    = busy && bus.i_res_valid && bus.i_dst_ready
                    && (inflight != '0) && (retired < len_q);

        bus.o_busy        = busy;
        bus.o_done        = (state == DONE);
        bus.o_err         = bus.i_start && (state != IDLE);
        bus.o_src_ready   = src_ready;
        bus.o_mac_valid   = issue;
        bus.o_mac_inhibit = inhibit;
        bus.o_first       = issue && (issued == '0);
        bus.o_last        = issue && (issued == len_m1);
        bus.o_q_frac      = q_frac_q;
        bus.o_res_last    = busy && bus.i_res_valid && (retired == len_m1);
    end

    // Job parameters and term counters; stalls hold everything by construction
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            len_q    <= '0;
            q_frac_q <= '0;
            issued   <= '0;
            retired  <= '0;
            inflight <= '0;
        end else if (state == IDLE && bus.i_start) begin
            len_q    <= bus.i_len;
            q_frac_q <= bus.i_q_frac;
            issued   <= '0;
            retired  <= '0;
            inflight <= '0;
        end else begin
            if (issue) begin
                issued <= issued + LEN_W'(1);
            end
            if (retire) begin
                retired <= retired + LEN_W'(1);
            end
            if (issue && !retire) begin
                inflight <= inflight + IF_W'(1);
            end else if (!issue && retire) begin
                inflight <= inflight - IF_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl: a driver issues jobs and pushes the expected beat,
// result and done records into queues; a monitor pops and compares whenever
// the sequencer presents a beat, a retiring result or a done pulse.
module tb_mac_seq_ctrl;
    localparam int PIPE_DEPTH = 4;
    localparam int LEN_W      = 10;
    localparam int QF_W       = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mac_seq_ctrl_if #(.LEN_W(LEN_W), .QF_W(QF_W)) bus ();

    mac_seq_ctrl #(
        .PIPE_DEPTH(PIPE_DEPTH),
        .LEN_W     (LEN_W),
        .QF_W      (QF_W)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    typedef struct {
        bit            first;
        bit            last;
        logic [QF_W-1:0] q;
    } beat_t;

    typedef struct {
        int len;
        int start_cyc;
        int exp_total;
    } job_t;

    beat_t issue_q[$];
    bit    res_q[$];
    job_t  done_q[$];

    int n_pass       = 0;
    int n_total      = 0;
    int cyc          = 0;
    int jobs_started = 0;
    int jobs_done    = 0;
    int n_issued     = 0;
    int last_ret_cyc = 0;
    bit exp_err      = 1'b0;

    // behavioural MAC chain: PIPE_DEPTH stages, frozen while inhibited, not reset
    logic [PIPE_DEPTH-1:0] pv = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // stage chain model
    always @(posedge clk) begin
        if (!bus.o_mac_inhibit) pv <= {pv[PIPE_DEPTH-2:0], bus.o_mac_valid};
    end

    task automatic check(input string name, input int act, input int want);
        n_total++;
        if (act == want) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, want, cyc);
    endtask

    // reference: a job of len terms yields len beats, first/last on the ends,
    // len results with the final one flagged, and exactly one done
    task automatic push_job(input int len, input int q, input int exp_total);
        beat_t b;
        job_t  j;
        for (int k = 0; k < len; k++) begin
            b.first = (k == 0);
            b.last  = (k == len - 1);
            b.q     = QF_W'(q);
            issue_q.push_back(b);
            res_q.push_back(k == len - 1);
        end
        j.len       = len;
        j.start_cyc = cyc;
        j.exp_total = exp_total;
        done_q.push_back(j);
        jobs_started++;
    endtask

    task automatic next_cycle(input bit sv, input bit dr);
        @(negedge clk);
        bus.i_res_valid = pv[PIPE_DEPTH-1];
        bus.i_src_valid = sv;
        bus.i_dst_ready = dr;
        bus.i_start     = 1'b0;
        exp_err         = 1'b0;
    endtask

    task automatic do_reset();
        next_cycle(1'b0, 1'b1);
        rst = 1'b1;
        next_cycle(1'b0, 1'b1);
        rst = 1'b0;
        repeat (PIPE_DEPTH + 1) next_cycle(1'b0, 1'b1);
    endtask

    task automatic run_job(input int len, input int q, input int src_pct, input int dst_pct,
                           input int exp_total, input bit stray,
                           input logic [31:0] src_gap, input logic [31:0] dst_gap);
        int k;
        bit sv;
        bit dr;
        next_cycle(1'b1, 1'b1);
        bus.i_start  = 1'b1;
        bus.i_len    = LEN_W'(len);
        bus.i_q_frac = QF_W'(q);
        push_job(len, q, exp_total);
        k = 1;
        while (jobs_started != jobs_done && k < 600) begin
            sv = (int'($urandom_range(99)) < src_pct) && !(k < 32 && src_gap[k]);
            dr = (int'($urandom_range(99)) < dst_pct) && !(k < 32 && dst_gap[k]);
            next_cycle(sv, dr);
            if (stray && len > 0 && k == 2) begin
                bus.i_start  = 1'b1;
                bus.i_len    = LEN_W'($urandom_range(1, 50));
                bus.i_q_frac = ~QF_W'(q);
                exp_err      = 1'b1;
            end
            k++;
        end
        check("job_finished", int'(jobs_started == jobs_done), 1);
        if (jobs_started != jobs_done) do_reset();
    endtask

    // monitor / scoreboard
    initial begin
        beat_t b;
        job_t  j;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                issue_q.delete();
                res_q.delete();
                done_q.delete();
                jobs_done = jobs_started;
            end else begin
                check("inhibit", bus.o_mac_inhibit, bus.i_res_valid & ~bus.i_dst_ready);
                check("err", bus.o_err, exp_err);
                if (bus.o_mac_valid) begin
                    n_issued++;
                    check("issue_legal", bus.i_src_valid & ~bus.o_mac_inhibit, 1);
                    check("issue_expected", int'(issue_q.size() != 0), 1);
                    if (issue_q.size() != 0) begin
                        b = issue_q.pop_front();
                        check("first", bus.o_first, b.first);
                        check("last", bus.o_last, b.last);
                        check("q_frac", bus.o_q_frac, b.q);
                    end
                end else begin
                    check("first_last_quiet", {bus.o_first, bus.o_last}, 0);
                end
                if (bus.i_res_valid) begin
                    if (jobs_started != jobs_done) begin
                        check("res_last", bus.o_res_last, int'(res_q.size() == 1));
                        if (bus.i_dst_ready) begin
                            check("result_expected", int'(res_q.size() != 0), 1);
                            if (res_q.size() != 0) begin
                                void'(res_q.pop_front());
                                last_ret_cyc = cyc;
                            end
                        end
                    end else begin
                        check("res_last_idle", bus.o_res_last, 0);
                    end
                end
                if (bus.o_done) begin
                    check("done_expected", int'(done_q.size() != 0), 1);
                    if (done_q.size() != 0) begin
                        j = done_q.pop_front();
                        check("done_nothing_pending", issue_q.size() + res_q.size(), 0);
                        if (j.len == 0) check("done_zero_len_latency", cyc - j.start_cyc, 1);
                        else check("done_after_retire", cyc - last_ret_cyc, 1);
                        if (j.exp_total != 0) check("job_time", cyc - j.start_cyc, j.exp_total);
                        jobs_done++;
                    end
                end
            end
        end
    end

    // driver
    initial begin
        int base;
        int len;
        bus.i_start     = 1'b0;
        bus.i_len       = '0;
        bus.i_q_frac    = '0;
        bus.i_src_valid = 1'b0;
        bus.i_res_valid = 1'b0;
        bus.i_dst_ready = 1'b0;
        rst = 1'b1;
        next_cycle(1'b0, 1'b0);
        next_cycle(1'b0, 1'b0);
        rst = 1'b0;
        next_cycle(1'b1, 1'b1);
        #1;
        check("reset_busy", bus.o_busy, 0);
        check("reset_done", bus.o_done, 0);
        check("reset_src_ready", bus.o_src_ready, 0);
        check("reset_mac_valid", bus.o_mac_valid, 0);
        check("reset_q_frac", bus.o_q_frac, 0);

        // plain job, no stalls
        run_job(4, 5, 100, 100, 4 + PIPE_DEPTH + 1, 1'b0, '0, '0);
        // zero-length job
        run_job(0, 3, 100, 100, 0, 1'b0, '0, '0);
        // result back-pressure for three cycles
        run_job(6, 9, 100, 100, 0, 1'b0, '0, 32'h0000_01C0);
        // start request while running
        run_job(7, 17, 100, 100, 0, 1'b1, '0, '0);
        // operand gap in cycles 2-3
        run_job(5, 21, 100, 100, 0, 1'b0, 32'h0000_000C, '0);

        // reset in the middle of a LEN=8 job after three issues
        base = n_issued;
        next_cycle(1'b1, 1'b1);
        bus.i_start  = 1'b1;
        bus.i_len    = LEN_W'(8);
        bus.i_q_frac = QF_W'(13);
        push_job(8, 13, 0);
        repeat (3) next_cycle(1'b1, 1'b1);
        #3;
        check("t1_issued_before_reset", n_issued - base, 3);
        next_cycle(1'b1, 1'b1);
        rst = 1'b1;
        next_cycle(1'b1, 1'b1);
        rst = 1'b0;
        #1;
        check("t1_busy", bus.o_busy, 0);
        check("t1_done", bus.o_done, 0);
        check("t1_src_ready", bus.o_src_ready, 0);
        check("t1_mac_valid", bus.o_mac_valid, 0);
        check("t1_q_frac", bus.o_q_frac, 0);
        check("t1_res_last", bus.o_res_last, 0);
        repeat (PIPE_DEPTH + 4) next_cycle(1'b1, 1'b1);

        // short jobs at full rate must hit the minimum job time
        repeat (4) begin
            len = int'($urandom_range(1, PIPE_DEPTH));
            run_job(len, int'($urandom_range(0, 31)), 100, 100, len + PIPE_DEPTH + 1,
                    1'b0, '0, '0);
        end

        // randomized traffic
        repeat (30) begin
            len = int'($urandom_range(0, 12));
            run_job(len, int'($urandom_range(0, 31)), int'($urandom_range(40, 100)),
                    int'($urandom_range(40, 100)), 0, 1'($urandom_range(0, 1)), '0, '0);
        end

        repeat (4) next_cycle(1'b0, 1'b1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // absolute time bound
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_total);
        $fatal(1);
    end
endmodule
